load_align_unit: RTL and testbench
==================================

# load_align_unit

Parametrised load-alignment unit: the sequential successor to the combinational load select mux in the writeback path. It sits between the memory stage and the data-memory port. It accepts one load request at a time and issues one or two word-aligned memory reads, two when a misaligned access crosses a word boundary. It shifts, merges and sign- or zero-extends the result, then hands it to writeback with the destination tag. It generalises width (32/64-bit), adds misaligned-load support, and adds valid/ready handshakes on every side.

## Interface
- XLEN, 32: datapath and memory word width; legal values are 32 and 64.
- ADDR_W, 32: byte-address width.
- MISALIGN_EN, 1: 1 = split boundary-crossing loads into two reads; 0 = raise a fault instead.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit idle and able to accept a request.
- req_addr  in  ADDR_W  byte address.
- req_ldsel  in  3  load type: LB 000, LH 001, LW 010, LBU 011, LHU 100, LWU 101 (XLEN=64 only), LD 110 (XLEN=64 only).
- req_rd  in  5  destination register tag.
- mem_req_valid  out  1  word read request.
- mem_req_ready  in  1  memory accepts the read.
- mem_req_addr  out  ADDR_W  word-aligned address; low log2(XLEN/8) bits are always 0.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  XLEN  read word, little-endian.
- wb_valid  out  1  result valid.
- wb_ready  in  1  writeback accepts the result.
- wb_data  out  XLEN  extended load result.
- wb_rd  out  5  echoed request tag.
- wb_fault  out  1  misaligned access with MISALIGN_EN=0, or illegal ldsel.

## Operation
- Size is fixed by ldsel: B=1, H=2, W=4, D=8 bytes. off = addr mod (XLEN/8). The access crosses a word boundary when off+size > XLEN/8.
- FSM states: IDLE, RD0, WAIT0, RD1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, register addr, ldsel and rd.
  - If ldsel is illegal, or the access crosses and MISALIGN_EN=0: go to RESP with wb_fault=1, wb_data=0, and issue no memory request.
  - Otherwise go to RD0.
- RD0: mem_req_valid=1, address = the word containing addr. On mem_req_ready go to WAIT0.
- WAIT0: on mem_rsp_valid, capture the response as word0. Go to RD1 if the access crosses, else to RESP.
- RD1: request the address of word0 + XLEN/8. Wrap-around at 2^ADDR_W is modulo. On mem_req_ready go to WAIT1.
- WAIT1: on mem_rsp_valid, capture the response as word1 and go to RESP.
- Merge: {word1, word0} >> (8*off). For a non-crossing access, word1 is don't-care.
  - Take the low size bytes.
  - Sign-extend for LB, LH, LW and LD. Zero-extend for LBU, LHU and LWU.
  - For XLEN=32, LW is passed through unextended.
- RESP: hold wb_valid=1 with wb_data, wb_rd and wb_fault stable until wb_ready; then go to IDLE.
- Only one request is outstanding. req_ready is 0 in every state except IDLE. There is no request/response overlap.
- A mem_rsp_valid outside WAIT0 or WAIT1 is ignored.
- Reset: rst_n low from any state forces IDLE immediately.
  - All outputs go to 0: req_ready, mem_req_valid, mem_req_addr, wb_valid, wb_data, wb_rd, wb_fault.
  - Any in-flight request is dropped.
  - req_ready becomes 1 on the first clock edge after reset deasserts.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Aligned load, zero-wait memory: request accepted in cycle 0, mem_req_valid in cycle 1, response in cycle 2, wb_valid in cycle 3. Minimum latency is 3 cycles.
- Crossing load: minimum latency 5 cycles.
- Fault: wb_valid in cycle 1.
- mem_req_addr is stable while mem_req_valid is high and mem_req_ready is low.

## Structure
- Package load_align_pkg holds:
  - the LDSEL_* encodings;
  - the state enum;
  - a function returning the size for a given ldsel.
- Sub-module load_extract: purely combinational. Inputs: {word1, word0}, off, ldsel. Output: the extended result. It is reused by the FSM wrapper.

## Test plan
- XLEN=32, mem[0x100]=0xDEADBEEF, LB at 0x103 -> one read of 0x100; wb_data=0xFFFFFFDE.
- LHU at 0x102 -> wb_data=0x0000DEAD; no second read.
- MISALIGN_EN=1, mem[0x104]=0x11223344:
  - LW at 0x102 -> reads 0x100 then 0x104; wb_data=0x3344DEAD.
  - LH at 0x103 -> wb_data=0x000044DE.
- MISALIGN_EN=0, LW at 0x101 -> no mem_req_valid; wb_valid in cycle 1 with wb_fault=1 and wb_data=0. Same response for ldsel 111.
- wb_ready low for 3 cycles and mem_req_ready low for 2 cycles -> outputs hold stable and req_ready stays 0. Assert rst_n low during WAIT1 -> all outputs 0 and a late mem_rsp_valid is ignored.
- XLEN=64, mem[0x0]=0x8877665544332211:
  - LD at 0x0 -> 0x8877665544332211.
  - LWU at 0x4 -> 0x0000000088776655.
  - LW at 0x4 -> 0xFFFFFFFF88776655.

Source files
------------

// File: rtl/load_align_pkg.sv
// Shared encodings, FSM state type and load-size helpers for the load alignment unit.
package load_align_pkg;

    localparam logic [2:0] LDSEL_LB  = 3'b000;
    localparam logic [2:0] LDSEL_LH  = 3'b001;
    localparam logic [2:0] LDSEL_LW  = 3'b010;
    localparam logic [2:0] LDSEL_LBU = 3'b011;
    localparam logic [2:0] LDSEL_LHU = 3'b100;
    localparam logic [2:0] LDSEL_LWU = 3'b101;
    localparam logic [2:0] LDSEL_LD  = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD0   = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_RD1   = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    // Access size in bytes; 0 marks an encoding with no defined size.
    function automatic logic [3:0] ldsel_size(input logic [2:0] ldsel);
        case (ldsel)
            LDSEL_LB, LDSEL_LBU: return 4'd1;
            LDSEL_LH, LDSEL_LHU: return 4'd2;
            LDSEL_LW, LDSEL_LWU: return 4'd4;
            LDSEL_LD:            return 4'd8;
            default:             return 4'd0;
        endcase
    endfunction

    function automatic logic ldsel_legal(input logic [2:0] ldsel, input logic is_64);
        case (ldsel)
            LDSEL_LB, LDSEL_LH, LDSEL_LW, LDSEL_LBU, LDSEL_LHU: return 1'b1;
            LDSEL_LWU, LDSEL_LD:                                return is_64;
            default:                                            return 1'b0;
        endcase
    endfunction

    function automatic logic ldsel_signed(input logic [2:0] ldsel);
        return (ldsel == LDSEL_LB) || (ldsel == LDSEL_LH) ||
               (ldsel == LDSEL_LW) || (ldsel == LDSEL_LD);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte extraction: shifts a two-word window down by the byte offset,
// keeps the access-sized low bytes and sign- or zero-extends them to XLEN.
module load_extract
    import load_align_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]          pair,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [2:0]                 ldsel,
    output logic [XLEN-1:0]            result
);

    logic [3:0]      size;
    logic [6:0]      size_bits;
    logic [XLEN-1:0] low;
    logic [XLEN-1:0] mask;
    logic            sign;

    // A full-width access leaves mask all ones, so no extension bits are added.
    always_comb begin
        size      = ldsel_size(ldsel);
        size_bits = {size, 3'b000};
        low       = XLEN'(pair >> {off, 3'b000});
        mask      = '1;
        if (size_bits < 7'(XLEN)) begin
            mask = ~({XLEN{1'b1}} << size_bits);
        end
        case (size)
            4'd1:    sign = low[7];
            4'd2:    sign = low[15];
            4'd4:    sign = low[31];
            4'd8:    sign = low[XLEN-1];
            default: sign = 1'b0;
        endcase
        if (size == 4'd0) begin
            result = '0;
        end else begin
            result = (low & mask) | ((sign && ldsel_signed(ldsel)) ? ~mask : '0);
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load alignment unit: issues one or two word reads per load, merges and
// extends the bytes, and returns the result with its destination tag.
module load_align_unit
    import load_align_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_ldsel,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_fault
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  off_q;
    logic [2:0]        ldsel_q;
    logic [4:0]        rd_q;
    logic              cross_q;
    logic [XLEN-1:0]   word0_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   wb_data_q;
    logic [4:0]        wb_rd_q;
    logic              wb_fault_q;
    logic              req_ready_q;
    logic              mem_req_valid_q;
    logic              wb_valid_q;

    logic [OFF_W-1:0]  req_off;
    logic [4:0]        req_span;
    logic              req_cross;
    logic              req_fault;
    logic [ADDR_W-1:0] word_base;
    logic [2*XLEN-1:0] ext_pair;
    logic [XLEN-1:0]   ext_result;

    assign req_off   = req_addr[OFF_W-1:0];
    assign req_span  = 5'(req_off) + 5'(ldsel_size(req_ldsel));
    assign req_cross = req_span > 5'(BYTES);
    assign req_fault = !ldsel_legal(req_ldsel, XLEN == 64) || (req_cross && !MISALIGN_EN);
    assign word_base = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // The live response is word1 in WAIT1 and word0 otherwise.
    assign ext_pair = (state_q == ST_WAIT1) ? {mem_rsp_data, word0_q}
                                            : {{XLEN{1'b0}}, mem_rsp_data};

    load_extract #(.XLEN(XLEN)) u_extract (
        .pair   (ext_pair),
        .off    (off_q),
        .ldsel  (ldsel_q),
        .result (ext_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid)     state_d = req_fault ? ST_RESP : ST_RD0;
            ST_RD0:   if (mem_req_ready) state_d = ST_WAIT0;
            ST_WAIT0: if (mem_rsp_valid) state_d = cross_q ? ST_RD1 : ST_RESP;
            ST_RD1:   if (mem_req_ready) state_d = ST_WAIT1;
            ST_WAIT1: if (mem_rsp_valid) state_d = ST_RESP;
            ST_RESP:  if (wb_ready)      state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so none depends on an input combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            off_q           <= '0;
            ldsel_q         <= '0;
            rd_q            <= '0;
            cross_q         <= 1'b0;
            word0_q         <= '0;
            mem_addr_q      <= '0;
            wb_data_q       <= '0;
            wb_rd_q         <= '0;
            wb_fault_q      <= 1'b0;
            req_ready_q     <= 1'b0;
            mem_req_valid_q <= 1'b0;
            wb_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= (state_d == ST_IDLE);
            mem_req_valid_q <= (state_d == ST_RD0) || (state_d == ST_RD1);
            wb_valid_q      <= (state_d == ST_RESP);
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        off_q      <= req_off;
                        ldsel_q    <= req_ldsel;
                        rd_q       <= req_rd;
                        cross_q    <= req_cross;
                        mem_addr_q <= word_base;
                        if (req_fault) begin
                            wb_data_q  <= '0;
                            wb_rd_q    <= req_rd;
                            wb_fault_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT0: begin
                    if (mem_rsp_valid) begin
                        word0_q <= mem_rsp_data;
                        if (cross_q) begin
                            mem_addr_q <= mem_addr_q + ADDR_W'(BYTES);
                        end else begin
                            wb_data_q  <= ext_result;
                            wb_rd_q    <= rd_q;
                            wb_fault_q <= 1'b0;
                        end
                    end
                end
                ST_WAIT1: begin
                    if (mem_rsp_valid) begin
                        wb_data_q  <= ext_result;
                        wb_rd_q    <= rd_q;
                        wb_fault_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_addr_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign wb_fault      = wb_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: three instances (32-bit misaligned, 32-bit faulting, 64-bit).
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_ldsel = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;
    logic        wb_ready = 1'b0;
    logic        a_req_valid = 1'b0, b_req_valid = 1'b0, c_req_valid = 1'b0;

    logic        a_req_ready, a_mem_req_valid, a_wb_valid, a_wb_fault;
    logic [31:0] a_mem_req_addr, a_wb_data;
    logic [4:0]  a_wb_rd;
    logic        b_req_ready, b_mem_req_valid, b_wb_valid, b_wb_fault;
    logic [31:0] b_mem_req_addr, b_wb_data;
    logic [4:0]  b_wb_rd;
    logic        c_req_ready, c_mem_req_valid, c_wb_valid, c_wb_fault;
    logic [31:0] c_mem_req_addr;
    logic [63:0] c_wb_data;
    logic [4:0]  c_wb_rd;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(req_addr), .req_ldsel(req_ldsel), .req_rd(req_rd),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(a_mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data[31:0]),
        .wb_valid(a_wb_valid), .wb_ready(wb_ready), .wb_data(a_wb_data), .wb_rd(a_wb_rd), .wb_fault(a_wb_fault)
    );

    load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(req_addr), .req_ldsel(req_ldsel), .req_rd(req_rd),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(b_mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data[31:0]),
        .wb_valid(b_wb_valid), .wb_ready(wb_ready), .wb_data(b_wb_data), .wb_rd(b_wb_rd), .wb_fault(b_wb_fault)
    );

    load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .req_valid(c_req_valid), .req_ready(c_req_ready),
        .req_addr(req_addr), .req_ldsel(req_ldsel), .req_rd(req_rd),
        .mem_req_valid(c_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(c_mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .wb_valid(c_wb_valid), .wb_ready(wb_ready), .wb_data(c_wb_data), .wb_rd(c_wb_rd), .wb_fault(c_wb_fault)
    );

    // Inputs change and outputs are sampled on the falling edge; each helper spans one cycle.
    task automatic send_req(input int which, input logic [31:0] addr, input logic [2:0] sel, input logic [4:0] rd);
        req_addr = addr; req_ldsel = sel; req_rd = rd;
        a_req_valid = (which == 0); b_req_valid = (which == 1); c_req_valid = (which == 2);
        @(negedge clk);
        a_req_valid = 1'b0; b_req_valid = 1'b0; c_req_valid = 1'b0;
    endtask

    task automatic mem_accept();
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
    endtask

    task automatic mem_respond(input logic [63:0] data);
        mem_rsp_valid = 1'b1; mem_rsp_data = data;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    task automatic wb_accept();
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (a_req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_req_ready: got %b want 0", a_req_ready); end
        compared++; if (a_mem_req_valid !== 1'b0 || a_mem_req_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_mem: got %b/%h want 0/0", a_mem_req_valid, a_mem_req_addr); end
        compared++; if ({a_wb_valid, a_wb_fault, a_wb_rd, a_wb_data} !== '0) begin mismatched++; $display("[TB] FAIL rst_wb: got v%b f%b rd%h d%h want all 0", a_wb_valid, a_wb_fault, a_wb_rd, a_wb_data); end
        compared++; if (b_mem_req_addr !== 32'h0 || c_wb_data !== 64'h0) begin mismatched++; $display("[TB] FAIL rst_others: got %h/%h want 0/0", b_mem_req_addr, c_wb_data); end
        rst_n = 1'b1;
        @(negedge clk);
        compared++; if ({a_req_ready, b_req_ready, c_req_ready} !== 3'b111) begin mismatched++; $display("[TB] FAIL rst_release_ready: got %b want 111", {a_req_ready, b_req_ready, c_req_ready}); end
    endtask

    task automatic test_aligned();
        send_req(0, 32'h103, 3'b000, 5'd5);
        compared++; if (a_mem_req_valid !== 1'b1 || a_mem_req_addr !== 32'h100) begin mismatched++; $display("[TB] FAIL lb_rd0: got %b/%h want 1/00000100", a_mem_req_valid, a_mem_req_addr); end
        compared++; if (a_req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL lb_busy_ready: got %b want 0", a_req_ready); end
        mem_accept();
        compared++; if (a_mem_req_valid !== 1'b0 || a_wb_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL lb_wait0: got mv%b wv%b want 0/0", a_mem_req_valid, a_wb_valid); end
        mem_respond(64'hDEADBEEF);
        compared++; if (a_wb_valid !== 1'b1 || a_wb_data !== 32'hFFFFFFDE) begin mismatched++; $display("[TB] FAIL lb_data: got v%b %h want 1/FFFFFFDE", a_wb_valid, a_wb_data); end
        compared++; if (a_wb_rd !== 5'd5 || a_wb_fault !== 1'b0) begin mismatched++; $display("[TB] FAIL lb_tag: got rd%0d f%b want 5/0", a_wb_rd, a_wb_fault); end
        wb_accept();
        compared++; if (a_req_ready !== 1'b1 || a_wb_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL lb_idle: got r%b v%b want 1/0", a_req_ready, a_wb_valid); end

        send_req(0, 32'h102, 3'b100, 5'd6);
        mem_accept();
        mem_respond(64'hDEADBEEF);
        compared++; if (a_wb_valid !== 1'b1 || a_wb_data !== 32'h0000DEAD) begin mismatched++; $display("[TB] FAIL lhu_data: got v%b %h want 1/0000DEAD", a_wb_valid, a_wb_data); end
        compared++; if (a_mem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL lhu_no_rd1: got %b want 0", a_mem_req_valid); end
        wb_accept();
    endtask

    task automatic test_crossing();
        send_req(0, 32'h102, 3'b010, 5'd7);
        compared++; if (a_mem_req_addr !== 32'h100) begin mismatched++; $display("[TB] FAIL lw_x_addr0: got %h want 00000100", a_mem_req_addr); end
        mem_accept();
        mem_respond(64'hDEADBEEF);
        compared++; if (a_mem_req_valid !== 1'b1 || a_mem_req_addr !== 32'h104 || a_wb_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL lw_x_rd1: got mv%b %h wv%b want 1/00000104/0", a_mem_req_valid, a_mem_req_addr, a_wb_valid); end
        mem_accept();
        mem_respond(64'h11223344);
        compared++; if (a_wb_valid !== 1'b1 || a_wb_data !== 32'h3344DEAD || a_wb_rd !== 5'd7) begin mismatched++; $display("[TB] FAIL lw_x_data: got v%b %h rd%0d want 1/3344DEAD/7", a_wb_valid, a_wb_data, a_wb_rd); end
        wb_accept();

        send_req(0, 32'h103, 3'b001, 5'd8);
        mem_accept();
        mem_respond(64'hDEADBEEF);
        mem_accept();
        mem_respond(64'h11223344);
        compared++; if (a_wb_valid !== 1'b1 || a_wb_data !== 32'h000044DE) begin mismatched++; $display("[TB] FAIL lh_x_data: got v%b %h want 1/000044DE", a_wb_valid, a_wb_data); end
        wb_accept();
    endtask

    task automatic test_fault();
        send_req(1, 32'h101, 3'b010, 5'd3);
        compared++; if (b_wb_valid !== 1'b1 || b_wb_fault !== 1'b1 || b_wb_data !== 32'h0) begin mismatched++; $display("[TB] FAIL mis_fault: got v%b f%b %h want 1/1/0", b_wb_valid, b_wb_fault, b_wb_data); end
        compared++; if (b_mem_req_valid !== 1'b0 || b_wb_rd !== 5'd3 || b_req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mis_fault_side: got mv%b rd%0d r%b want 0/3/0", b_mem_req_valid, b_wb_rd, b_req_ready); end
        wb_accept();
        send_req(1, 32'h100, 3'b111, 5'd4);
        compared++; if (b_wb_valid !== 1'b1 || b_wb_fault !== 1'b1 || b_wb_data !== 32'h0 || b_mem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ldsel7_fault: got v%b f%b %h mv%b want 1/1/0/0", b_wb_valid, b_wb_fault, b_wb_data, b_mem_req_valid); end
        wb_accept();
        send_req(0, 32'h100, 3'b101, 5'd2);
        compared++; if (a_wb_valid !== 1'b1 || a_wb_fault !== 1'b1 || a_mem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL lwu32_fault: got v%b f%b mv%b want 1/1/0", a_wb_valid, a_wb_fault, a_mem_req_valid); end
        wb_accept();
    endtask

    task automatic test_stall();
        send_req(0, 32'h100, 3'b010, 5'd9);
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h55555555;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            compared++; if (a_mem_req_valid !== 1'b1 || a_mem_req_addr !== 32'h100 || a_req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_mem_%0d: got mv%b %h r%b want 1/00000100/0", i, a_mem_req_valid, a_mem_req_addr, a_req_ready); end
        end
        mem_accept();
        mem_respond(64'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            compared++; if (a_wb_valid !== 1'b1 || a_wb_data !== 32'hDEADBEEF || a_wb_rd !== 5'd9 || a_req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_wb_%0d: got v%b %h rd%0d r%b want 1/DEADBEEF/9/0", i, a_wb_valid, a_wb_data, a_wb_rd, a_req_ready); end
            @(negedge clk);
        end
        wb_accept();
        compared++; if (a_wb_valid !== 1'b0 || a_req_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_done: got v%b r%b want 0/1", a_wb_valid, a_req_ready); end
    endtask

    task automatic test_reset_wait1();
        send_req(0, 32'h102, 3'b010, 5'd11);
        mem_accept();
        mem_respond(64'hDEADBEEF);
        mem_accept();
        #2 rst_n = 1'b0;
        #1;
        compared++; if ({a_req_ready, a_mem_req_valid, a_wb_valid, a_wb_fault} !== 4'b0 || a_mem_req_addr !== 32'h0 || a_wb_data !== 32'h0 || a_wb_rd !== 5'd0) begin mismatched++; $display("[TB] FAIL rst_wait1: got r%b mv%b %h v%b f%b %h rd%0d want all 0", a_req_ready, a_mem_req_valid, a_mem_req_addr, a_wb_valid, a_wb_fault, a_wb_data, a_wb_rd); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h11223344;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        compared++; if (a_req_ready !== 1'b1 || a_wb_valid !== 1'b0 || a_mem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL late_rsp: got r%b v%b mv%b want 1/0/0", a_req_ready, a_wb_valid, a_mem_req_valid); end
        @(negedge clk);
        compared++; if (a_wb_valid !== 1'b0 || a_wb_data !== 32'h0) begin mismatched++; $display("[TB] FAIL late_rsp_hold: got v%b %h want 0/0", a_wb_valid, a_wb_data); end
    endtask

    task automatic test_xlen64();
        send_req(2, 32'h0, 3'b110, 5'd1);
        compared++; if (c_mem_req_valid !== 1'b1 || c_mem_req_addr !== 32'h0 || c_req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL ld_rd0: got mv%b %h r%b want 1/0/0", c_mem_req_valid, c_mem_req_addr, c_req_ready); end
        mem_accept();
        mem_respond(64'h8877665544332211);
        compared++; if (c_wb_valid !== 1'b1 || c_wb_data !== 64'h8877665544332211 || c_wb_fault !== 1'b0 || c_wb_rd !== 5'd1) begin mismatched++; $display("[TB] FAIL ld_data: got v%b %h f%b rd%0d want 1/8877665544332211/0/1", c_wb_valid, c_wb_data, c_wb_fault, c_wb_rd); end
        wb_accept();
        send_req(2, 32'h4, 3'b101, 5'd2);
        compared++; if (c_mem_req_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL lwu64_addr: got %h want 0", c_mem_req_addr); end
        mem_accept();
        mem_respond(64'h8877665544332211);
        compared++; if (c_wb_data !== 64'h0000000088776655) begin mismatched++; $display("[TB] FAIL lwu64_data: got %h want 0000000088776655", c_wb_data); end
        wb_accept();
        send_req(2, 32'h4, 3'b010, 5'd3);
        mem_accept();
        mem_respond(64'h8877665544332211);
        compared++; if (c_wb_data !== 64'hFFFFFFFF88776655) begin mismatched++; $display("[TB] FAIL lw64_data: got %h want FFFFFFFF88776655", c_wb_data); end
        wb_accept();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_crossing();
        test_fault();
        test_stall();
        test_reset_wait1();
        test_xlen64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
